// File: rtl/align_stage.sv
// Floating-point add/sub alignment: stage 1 orders the operands by magnitude,
// stage 2 right-shifts the smaller mantissa with guard/round/sticky collection.
module align_stage #(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23,
    localparam int MW    = FRAC_W + 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              sign_a,
    input  logic              sign_b,
    input  logic [EXP_W-1:0]  expo_a,
    input  logic [EXP_W-1:0]  expo_b,
    input  logic [FRAC_W-1:0] frac_a,
    input  logic [FRAC_W-1:0] frac_b,
    input  logic              op_sub,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [MW-1:0]     big_mant,
    output logic [MW-1:0]     small_mant,
    output logic [EXP_W-1:0]  exp_out,
    output logic              sign_out,
    output logic              eff_sub,
    output logic              swapped
);

    logic              en1, en2;
    logic [EXP_W-1:0]  ea, eb;
    logic [MW-1:0]     ma, mb;
    logic              sb_eff, a_big;
    logic [31:0]       diff_ext;
    logic [MW-1:0]     lost_mask, shifted;

    logic              s1_valid_q, s1_valid_d;
    logic [EXP_W-1:0]  s1_diff_q, s1_diff_d;
    logic [MW-1:0]     s1_big_q, s1_big_d;
    logic [MW-1:0]     s1_small_q, s1_small_d;
    logic [EXP_W-1:0]  s1_exp_q, s1_exp_d;
    logic              s1_sign_q, s1_sign_d;
    logic              s1_eff_sub_q, s1_eff_sub_d;
    logic              s1_swap_q, s1_swap_d;

    logic              out_valid_q, out_valid_d;
    logic [MW-1:0]     big_mant_q, big_mant_d;
    logic [MW-1:0]     small_mant_q, small_mant_d;
    logic [EXP_W-1:0]  exp_out_q, exp_out_d;
    logic              sign_out_q, sign_out_d;
    logic              eff_sub_q, eff_sub_d;
    logic              swapped_q, swapped_d;

    assign en2      = !out_valid_q || out_ready;
    assign en1      = !s1_valid_q || en2;
    assign in_ready = en1 || rst;

    // Stage 1: denormals take effective exponent 1; full ties keep A as larger.
    always_comb begin
        ea     = (expo_a == '0) ? EXP_W'(1) : expo_a;
        eb     = (expo_b == '0) ? EXP_W'(1) : expo_b;
        ma     = {|expo_a, frac_a, 3'b000};
        mb     = {|expo_b, frac_b, 3'b000};
        sb_eff = sign_b ^ op_sub;
        a_big  = (ea > eb) || ((ea == eb) && (ma >= mb));

        s1_valid_d   = en1 ? in_valid : s1_valid_q;
        s1_diff_d    = s1_diff_q;
        s1_big_d     = s1_big_q;
        s1_small_d   = s1_small_q;
        s1_exp_d     = s1_exp_q;
        s1_sign_d    = s1_sign_q;
        s1_eff_sub_d = s1_eff_sub_q;
        s1_swap_d    = s1_swap_q;
        if (en1) begin
            s1_eff_sub_d = sign_a ^ sb_eff;
            s1_swap_d    = !a_big;
            if (a_big) begin
                s1_diff_d  = ea - eb;
                s1_big_d   = ma;
                s1_small_d = mb;
                s1_exp_d   = ea;
                s1_sign_d  = sign_a;
            end else begin
                s1_diff_d  = eb - ea;
                s1_big_d   = mb;
                s1_small_d = ma;
                s1_exp_d   = eb;
                s1_sign_d  = sb_eff;
            end
        end
    end

    // Stage 2: everything shifted out below bit 0 folds into the sticky bit.
    always_comb begin
        diff_ext  = 32'(s1_diff_q);
        lost_mask = ~({MW{1'b1}} << diff_ext);
        shifted   = s1_small_q >> diff_ext;
        if (diff_ext >= MW) begin
            shifted = MW'(|s1_small_q);
        end else begin
            shifted[0] = shifted[0] | (|(s1_small_q & lost_mask));
        end

        out_valid_d  = en2 ? s1_valid_q : out_valid_q;
        big_mant_d   = en2 ? s1_big_q     : big_mant_q;
        small_mant_d = en2 ? shifted      : small_mant_q;
        exp_out_d    = en2 ? s1_exp_q     : exp_out_q;
        sign_out_d   = en2 ? s1_sign_q    : sign_out_q;
        eff_sub_d    = en2 ? s1_eff_sub_q : eff_sub_q;
        swapped_d    = en2 ? s1_swap_q    : swapped_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            s1_diff_q    <= '0;
            s1_big_q     <= '0;
            s1_small_q   <= '0;
            s1_exp_q     <= '0;
            s1_sign_q    <= 1'b0;
            s1_eff_sub_q <= 1'b0;
            s1_swap_q    <= 1'b0;
            out_valid_q  <= 1'b0;
            big_mant_q   <= '0;
            small_mant_q <= '0;
            exp_out_q    <= '0;
            sign_out_q   <= 1'b0;
            eff_sub_q    <= 1'b0;
            swapped_q    <= 1'b0;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_diff_q    <= s1_diff_d;
            s1_big_q     <= s1_big_d;
            s1_small_q   <= s1_small_d;
            s1_exp_q     <= s1_exp_d;
            s1_sign_q    <= s1_sign_d;
            s1_eff_sub_q <= s1_eff_sub_d;
            s1_swap_q    <= s1_swap_d;
            out_valid_q  <= out_valid_d;
            big_mant_q   <= big_mant_d;
            small_mant_q <= small_mant_d;
            exp_out_q    <= exp_out_d;
            sign_out_q   <= sign_out_d;
            eff_sub_q    <= eff_sub_d;
            swapped_q    <= swapped_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign big_mant   = big_mant_q;
    assign small_mant = small_mant_q;
    assign exp_out    = exp_out_q;
    assign sign_out   = sign_out_q;
    assign eff_sub    = eff_sub_q;
    assign swapped    = swapped_q;

endmodule

// File: tb/tb_align_stage.sv
// Directed bench for align_stage: alignment cases, sticky handling, backpressure and reset.
module tb_align_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        sign_a = 1'b0, sign_b = 1'b0;
    logic [7:0]  expo_a = '0, expo_b = '0;
    logic [22:0] frac_a = '0, frac_b = '0;
    logic        op_sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [26:0] big_mant, small_mant;
    logic [7:0]  exp_out;
    logic        sign_out, eff_sub, swapped;

    int tests = 0;
    int fails = 0;

    align_stage #(.EXP_W(8), .FRAC_W(23)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sign_a(sign_a), .sign_b(sign_b), .expo_a(expo_a), .expo_b(expo_b),
        .frac_a(frac_a), .frac_b(frac_b), .op_sub(op_sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .big_mant(big_mant), .small_mant(small_mant), .exp_out(exp_out),
        .sign_out(sign_out), .eff_sub(eff_sub), .swapped(swapped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                          input logic sb, input logic [7:0] eb, input logic [22:0] fb,
                          input logic sub);
        in_valid = 1'b1;
        sign_a = sa; expo_a = ea; frac_a = fa;
        sign_b = sb; expo_b = eb; frac_b = fb;
        op_sub = sub;
    endtask

    // One transfer with out_ready high, then two edges to reach the output.
    task automatic apply(input logic sa, input logic [7:0] ea, input logic [22:0] fa,
                         input logic sb, input logic [7:0] eb, input logic [22:0] fb,
                         input logic sub);
        set_in(sa, ea, fa, sb, eb, fb, sub);
        tick();
        in_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got %b exp 0", out_valid); end
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
        tests++; if ({big_mant, small_mant, exp_out, sign_out, eff_sub, swapped} !== '0) begin
            fails++; $display("FAIL reset_data got %h %h %h %b%b%b exp 0", big_mant, small_mant, exp_out, sign_out, eff_sub, swapped);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        set_in(1'b0, 8'd130, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_latency1 got %b exp 0", out_valid); end
        tick();
        tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_latency2 got %b exp 1", out_valid); end
        tests++; if (big_mant !== 27'h4000000) begin fails++; $display("FAIL basic_big got %h exp 4000000", big_mant); end
        tests++; if (small_mant !== 27'h1000000) begin fails++; $display("FAIL basic_small got %h exp 1000000", small_mant); end
        tests++; if ({exp_out, swapped, eff_sub} !== {8'd130, 1'b0, 1'b0}) begin
            fails++; $display("FAIL basic_ctl got exp=%0d sw=%b es=%b exp 130 0 0", exp_out, swapped, eff_sub);
        end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_tie_sub();
        apply(1'b0, 8'd127, 23'h100000, 1'b0, 8'd127, 23'h200000, 1'b1);
        tests++; if (big_mant !== 27'h5000000) begin fails++; $display("FAIL tie_big got %h exp 5000000", big_mant); end
        tests++; if (small_mant !== 27'h4800000) begin fails++; $display("FAIL tie_small got %h exp 4800000", small_mant); end
        tests++; if ({swapped, sign_out, eff_sub, exp_out} !== {1'b1, 1'b1, 1'b1, 8'd127}) begin
            fails++; $display("FAIL tie_ctl got sw=%b s=%b es=%b e=%0d exp 1 1 1 127", swapped, sign_out, eff_sub, exp_out);
        end
    endtask

    task automatic test_swap_sign();
        // B larger by exponent; op_sub flips B negative to positive, so no effective subtract.
        apply(1'b0, 8'd128, 23'h0, 1'b1, 8'd130, 23'h0, 1'b1);
        tests++; if ({swapped, sign_out, eff_sub, exp_out} !== {1'b1, 1'b0, 1'b0, 8'd130}) begin
            fails++; $display("FAIL swap_ctl got sw=%b s=%b es=%b e=%0d exp 1 0 0 130", swapped, sign_out, eff_sub, exp_out);
        end
        tests++; if (small_mant !== 27'h1000000) begin fails++; $display("FAIL swap_small got %h exp 1000000", small_mant); end
        apply(1'b1, 8'd140, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tests++; if ({swapped, sign_out, eff_sub} !== 3'b011) begin
            fails++; $display("FAIL negA_ctl got sw=%b s=%b es=%b exp 0 1 1", swapped, sign_out, eff_sub);
        end
    endtask

    task automatic test_sticky();
        apply(1'b0, 8'd130, 23'h0, 1'b0, 8'd126, 23'h000001, 1'b0);
        tests++; if (small_mant !== 27'h0400001) begin fails++; $display("FAIL sticky_d4 got %h exp 0400001", small_mant); end
        apply(1'b0, 8'd170, 23'h0, 1'b0, 8'd130, 23'h000001, 1'b0);
        tests++; if (small_mant !== 27'h0000001) begin fails++; $display("FAIL far_small got %h exp 0000001", small_mant); end
        tests++; if (big_mant !== 27'h4000000 || exp_out !== 8'd170) begin
            fails++; $display("FAIL far_big got %h e=%0d exp 4000000 170", big_mant, exp_out);
        end
    endtask

    task automatic test_denormal();
        apply(1'b0, 8'd1, 23'h0, 1'b0, 8'd0, 23'h000001, 1'b0);
        tests++; if (big_mant !== 27'h4000000) begin fails++; $display("FAIL denorm_big got %h exp 4000000", big_mant); end
        tests++; if (small_mant !== 27'h0000008) begin fails++; $display("FAIL denorm_small got %h exp 0000008", small_mant); end
        tests++; if (exp_out !== 8'd1 || swapped !== 1'b0) begin
            fails++; $display("FAIL denorm_ctl got e=%0d sw=%b exp 1 0", exp_out, swapped);
        end
    endtask

    task automatic test_back_to_back();
        set_in(1'b0, 8'd131, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        set_in(1'b0, 8'd132, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        tests++; if (out_valid !== 1'b1 || exp_out !== 8'd131 || small_mant !== 27'h0800000) begin
            fails++; $display("FAIL b2b_0 got v=%b e=%0d s=%h exp 1 131 0800000", out_valid, exp_out, small_mant);
        end
        set_in(1'b0, 8'd133, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || exp_out !== 8'd132 || small_mant !== 27'h0400000) begin
            fails++; $display("FAIL b2b_1 got v=%b e=%0d s=%h exp 1 132 0400000", out_valid, exp_out, small_mant);
        end
        tick();
        tests++; if (out_valid !== 1'b1 || exp_out !== 8'd133 || small_mant !== 27'h0200000) begin
            fails++; $display("FAIL b2b_2 got v=%b e=%0d s=%h exp 1 133 0200000", out_valid, exp_out, small_mant);
        end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        set_in(1'b0, 8'd140, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL bp_ready1 got %b exp 1", in_ready); end
        set_in(1'b0, 8'd150, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        tick();
        tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL bp_ready2 got %b exp 0", in_ready); end
        set_in(1'b0, 8'd160, 23'h0, 1'b0, 8'd128, 23'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (out_valid !== 1'b1 || exp_out !== 8'd140 || small_mant !== 27'h0004000 || in_ready !== 1'b0) begin
                fails++; $display("FAIL bp_hold%0d got v=%b e=%0d s=%h r=%b exp 1 140 0004000 0", i, out_valid, exp_out, small_mant, in_ready);
            end
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        tests++; if (out_valid !== 1'b1 || exp_out !== 8'd150 || small_mant !== 27'h0000010) begin
            fails++; $display("FAIL bp_out1 got v=%b e=%0d s=%h exp 1 150 0000010", out_valid, exp_out, small_mant);
        end
        tick();
        tests++; if (out_valid !== 1'b1 || exp_out !== 8'd160 || small_mant !== 27'h0000001) begin
            fails++; $display("FAIL bp_out2 got v=%b e=%0d s=%h exp 1 160 0000001", out_valid, exp_out, small_mant);
        end
        tick();
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL bp_drain got %b exp 0", out_valid); end
    endtask

    task automatic test_reset_in_flight();
        logic seen;
        out_ready = 1'b0;
        set_in(1'b1, 8'd200, 23'h7FFFFF, 1'b0, 8'd190, 23'h0, 1'b1);
        tick();
        set_in(1'b0, 8'd210, 23'h123456, 1'b1, 8'd205, 23'h0, 1'b0);
        tick();
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL rstf_in_ready got %b exp 1", in_ready); end
        tick();
        rst = 1'b0;
        tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rstf_valid got %b exp 0", out_valid); end
        tests++; if ({big_mant, small_mant, exp_out, sign_out, eff_sub, swapped} !== '0) begin
            fails++; $display("FAIL rstf_data got %h %h %h exp 0", big_mant, small_mant, exp_out);
        end
        out_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_valid) seen = 1'b1;
        end
        tests++; if (seen !== 1'b0) begin fails++; $display("FAIL rstf_ghost got %b exp 0", seen); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_tie_sub();
        test_swap_sign();
        test_sticky();
        test_denormal();
        test_back_to_back();
        test_backpressure();
        test_reset_in_flight();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/align_stage.md
ALIGN_STAGE -- requirements
Module: align_stage

Interface
REQ-001 Parameter EXP_W, default 8, exponent field width.
REQ-002 Parameter FRAC_W, default 23, fraction field width; MW = FRAC_W+4 (hidden, fraction, guard, round, sticky).
REQ-003 clk  input  1  rising-edge clock; the block uses only this clock.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 in_valid  input  1  operand pair valid.
REQ-006 in_ready  output  1  block accepts the pair this cycle.
REQ-007 sign_a, sign_b  input  1 each  operand signs.
REQ-008 expo_a, expo_b  input  EXP_W each  biased exponents.
REQ-009 frac_a, frac_b  input  FRAC_W each  stored fractions.
REQ-010 op_sub  input  1  0 = A+B, 1 = A-B.
REQ-011 out_valid  output  1  aligned result valid.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 big_mant  output  MW  larger-magnitude mantissa {hidden, frac, 3'b000}.
REQ-014 small_mant  output  MW  smaller mantissa, right-aligned, with guard, round and sticky bits.
REQ-015 exp_out  output  EXP_W  larger effective exponent.
REQ-016 sign_out  output  1  sign of the larger-magnitude operand after op_sub is applied.
REQ-017 eff_sub  output  1  effective subtraction flag.
REQ-018 swapped  output  1  1 when B is the larger-magnitude operand.

Function
REQ-019 Hidden bit = (expo != 0); effective exponent = max(expo, 1), so denormals align as exponent 1.
REQ-020 Effective sign of B, sb' = sign_b XOR op_sub; eff_sub = sign_a XOR sb'.
REQ-021 Magnitude comparison first uses effective exponents; on a tie it uses {hidden, frac}. On a full tie A counts as larger and swapped = 0.
REQ-022 Stage 1 (registered) holds the exponent difference d = larger − smaller effective exponent (unsigned, EXP_W bits), the swap decision, both mantissas, exp_out, sign_out and eff_sub.
REQ-023 Stage 2 (registered) right-shifts {hidden, frac, 3'b000} of the smaller operand by d.
REQ-024 The sticky bit (bit 0) is the OR of every bit shifted past bit 0, ORed with the shifted bit 0 itself.
REQ-025 If d >= MW, small_mant = {(MW−1)'b0, OR of the smaller mantissa}.
REQ-026 If d = 0, small_mant is unshifted.
REQ-027 sign_out = sign_a when swapped = 0, else sb'.
REQ-028 Latency from input acceptance to out_valid is exactly 2 cycles when the pipeline is unstalled; throughput is 1 pair per cycle.
REQ-029 Stage enables: en2 = !out_valid | out_ready; en1 = !s1_valid | en2; in_ready = en1 (combinational).
REQ-030 An input transfer occurs when in_valid & in_ready; an output transfer occurs when out_valid & out_ready.
REQ-031 While out_valid = 1 and out_ready = 0, all outputs hold stable.
REQ-032 No transaction is dropped, duplicated or reordered.
REQ-033 A simultaneous input transfer and output transfer in one cycle is legal, and the pipeline keeps full throughput.
REQ-034 Data registers load only when their stage enable is high; valid bits clear when a stage is drained with no new data entering.
REQ-035 Inputs with expo = all-ones (Inf/NaN) pass through with the same alignment rules; special-case handling is downstream.

Reset
REQ-036 When rst = 1 at a clock edge, both stage valid bits clear, so out_valid = 0.
REQ-037 After reset, all data outputs read 0 (big_mant, small_mant, exp_out, sign_out, eff_sub, swapped).
REQ-038 During reset, in_ready = 1.
REQ-039 Reset asserted mid-operation discards every in-flight transaction; nothing is emitted after reset deasserts.

Verification (EXP_W=8, FRAC_W=23, MW=27)
REQ-040 A = (+, 130, 0), B = (+, 128, 0), op_sub = 0 -> 2 cycles later: big_mant = 27'h4000000, small_mant = 27'h1000000, exp_out = 130, swapped = 0, eff_sub = 0.
REQ-041 expo_a = expo_b = 127, frac_a = 23'h100000, frac_b = 23'h200000, signs +, op_sub = 1 -> swapped = 1, big_mant = 27'h5000000, small_mant = 27'h4800000, sign_out = 1, eff_sub = 1.
REQ-042 expo_a = 170, expo_b = 130 (d = 40), frac_b = 23'h000001 -> small_mant = 27'h0000001 (sticky only); big_mant = {1, frac_a, 000}.
REQ-043 Denormal: A = (+, 1, 0), B = (+, 0, 1) -> d = 0, swapped = 0, big_mant = 27'h4000000, small_mant = 27'h0000008, exp_out = 1.
REQ-044 Backpressure: hold out_ready = 0 and offer 3 back-to-back pairs -> in_ready falls after 2 acceptances and outputs stay stable; then set out_ready = 1 -> results emerge in order, with no loss and no duplication.
REQ-045 Reset with 2 transactions in flight -> out_valid = 0 on the next cycle, all outputs 0, and neither transaction ever appears.
